regfile16: RTL and testbench



---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile16_if.sv | 23 ++
 rtl/mux16_1.sv | 8 +
 rtl/mux2_1.sv | 9 +
 rtl/reg_word.sv | 21 ++
 rtl/regfile16.sv | 63 ++++++
 tb/tb_regfile16.sv | 195 +++++++++++++++++++
 7 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16-entry register file.
package regfile_pkg;
  localparam int          NUM_REGS = 16;
  localparam int          ADDR_W   = 4;
  localparam logic [3:0]  ZERO_IDX = 4'hF;

  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile16_if.sv
// Write port + two read ports of regfile16, grouped as one bus.
// master = writeback/decode side, slave = register file.
interface regfile16_if #(parameter int WIDTH = 64);
  import regfile_pkg::*;

  logic             wr_en;
  reg_addr_t        wr_addr;
  logic [WIDTH-1:0] wr_data;
  reg_addr_t        rd_addr_a;
  reg_addr_t        rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/mux16_1.sv
// Single-bit 16:1 mux; one instance per read-data bit.
module mux16_1 (
  input  logic [15:0] in_i,
  input  logic [3:0]  sel_i,
  output logic        out_o
);
  assign out_o = in_i[sel_i];
endmodule

// File: rtl/mux2_1.sv
// WIDTH-bit 2:1 mux; sel_i=1 picks b_i.
module mux2_1 #(parameter int WIDTH = 64) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/reg_word.sv
// One register-file entry: WIDTH-bit word, load enable, async active-high clear.
module reg_word #(parameter int WIDTH = 64) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q, data_d;

  // Hold unless this entry is selected for write.
  always_comb data_d = en_i ? d_i : data_q;

  // Reset has priority over a same-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;
endmodule

// File: rtl/regfile16.sv
// 16 x WIDTH register file: one synchronous write port, two combinational
// read ports built from bit-sliced mux16_1 trees.
// ZERO_REG=1 hardwires entry 15 to zero.
// Optional macro REGFILE_WR_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile16 import regfile_pkg::*; #(
  parameter int WIDTH    = 64,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  regfile16_if.slave bus
);
  logic [NUM_REGS-1:0]             wr_sel;
  logic [NUM_REGS-1:0][WIDTH-1:0]  regs;
  logic [WIDTH-1:0][NUM_REGS-1:0]  col;
  logic [WIDTH-1:0]                raw_a, raw_b;
  logic                            fwd_a, fwd_b;

  // One-hot write decode; the zero entry is never enabled when hardwired.
  always_comb begin
    wr_sel = '0;
    if (bus.wr_en && !(ZERO_REG && bus.wr_addr == ZERO_IDX))
      wr_sel[bus.wr_addr] = 1'b1;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .en_i  (wr_sel[r]),
      .d_i   (bus.wr_data),
      .q_o   (regs[r])
    );
  end

  // Transpose storage into per-bit columns; entry 15 reads as 0 when hardwired
  // so the result never depends on what its (unused) flop holds.
  always_comb begin
    col = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int r = 0; r < NUM_REGS; r++)
        col[i][r] = (ZERO_REG && r == int'(ZERO_IDX)) ? 1'b0 : regs[r][i];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux16_1 u_mux_a (.in_i(col[i]), .sel_i(bus.rd_addr_a), .out_o(raw_a[i]));
    mux16_1 u_mux_b (.in_i(col[i]), .sel_i(bus.rd_addr_b), .out_o(raw_b[i]));
  end

`ifdef REGFILE_WR_BYPASS_EN
  logic fwd_ok;
  // Forward only a write that will actually land in storage.
  assign fwd_ok = bus.wr_en && !reset && !(ZERO_REG && bus.wr_addr == ZERO_IDX);
  assign fwd_a  = fwd_ok && (bus.rd_addr_a == bus.wr_addr);
  assign fwd_b  = fwd_ok && (bus.rd_addr_b == bus.wr_addr);
`else
  assign fwd_a  = 1'b0;
  assign fwd_b  = 1'b0;
`endif

  mux2_1 #(.WIDTH(WIDTH)) u_byp_a (.a_i(raw_a), .b_i(bus.wr_data), .sel_i(fwd_a), .y_o(bus.rd_data_a));
  mux2_1 #(.WIDTH(WIDTH)) u_byp_b (.a_i(raw_b), .b_i(bus.wr_data), .sel_i(fwd_b), .y_o(bus.rd_data_b));
endmodule

// File: tb/tb_regfile16.sv
// Directed bench for regfile16: one ZERO_REG=1 and one ZERO_REG=0 instance.
module tb_regfile16;
  localparam int          WIDTH = 64;
  localparam logic [63:0] PAT   = 64'h0123_4567_89AB_CD00;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] V5    = 64'h5555_AAAA_5555_AAAA;

  logic clk, reset;
  int   total = 0;
  int   bad   = 0;

  regfile16_if #(.WIDTH(WIDTH)) bus();
  regfile16_if #(.WIDTH(WIDTH)) bus_nz();

  regfile16 #(.WIDTH(WIDTH), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  regfile16 #(.WIDTH(WIDTH), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .bus(bus_nz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [3:0] a, input logic [63:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.rd_addr_a = 4'd0; bus.rd_addr_b = 4'd9;
    bus_nz.rd_addr_a = 4'd15; bus_nz.rd_addr_b = 4'd3;
    #3 reset = 1'b1;   // before the first rising edge
    #1;
    total++;
    if (bus.rd_data_a !== 64'd0) begin bad++; $display("FAIL rst_async_a got=%h want=%h", bus.rd_data_a, 64'd0); end
    total++;
    if (bus.rd_data_b !== 64'd0) begin bad++; $display("FAIL rst_async_b got=%h want=%h", bus.rd_data_b, 64'd0); end
    total++;
    if (bus_nz.rd_data_a !== 64'd0) begin bad++; $display("FAIL rst_async_nz15 got=%h want=%h", bus_nz.rd_data_a, 64'd0); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_a = i[3:0];
      bus.rd_addr_b = 4'(15 - i);
      #1;
      total++;
      if (bus.rd_data_a !== 64'd0) begin bad++; $display("FAIL rst_read_a[%0d] got=%h want=%h", i, bus.rd_data_a, 64'd0); end
      total++;
      if (bus.rd_data_b !== 64'd0) begin bad++; $display("FAIL rst_read_b[%0d] got=%h want=%h", 15 - i, bus.rd_data_b, 64'd0); end
    end
  endtask

  task automatic test_write_all();
    logic [63:0] exp_a, exp_b;
    for (int i = 0; i < 15; i++) do_write(i[3:0], PAT | 64'(i));
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_a = i[3:0];
      bus.rd_addr_b = 4'(15 - i);
      exp_a = (i == 15) ? 64'd0 : (PAT | 64'(i));
      exp_b = (i == 0)  ? 64'd0 : (PAT | 64'(15 - i));
      #1;
      total++;
      if (bus.rd_data_a !== exp_a) begin bad++; $display("FAIL wr_read_a[%0d] got=%h want=%h", i, bus.rd_data_a, exp_a); end
      total++;
      if (bus.rd_data_b !== exp_b) begin bad++; $display("FAIL wr_read_b[%0d] got=%h want=%h", 15 - i, bus.rd_data_b, exp_b); end
    end
  endtask

  task automatic test_wr_en_low();
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd3; bus.wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd4;
    #1;
    total++;
    if (bus.rd_data_a !== 64'h0123_4567_89AB_CD03) begin bad++; $display("FAIL wren_low_r3 got=%h want=%h", bus.rd_data_a, 64'h0123_4567_89AB_CD03); end
    total++;
    if (bus.rd_data_b !== 64'h0123_4567_89AB_CD04) begin bad++; $display("FAIL wren_low_r4 got=%h want=%h", bus.rd_data_b, 64'h0123_4567_89AB_CD04); end
  endtask

  task automatic test_zero_reg();
    do_write(4'd15, ONES);
    bus.rd_addr_a = 4'd15; bus.rd_addr_b = 4'd15;
    #1;
    total++;
    if (bus.rd_data_a !== 64'd0) begin bad++; $display("FAIL zero15_a got=%h want=%h", bus.rd_data_a, 64'd0); end
    total++;
    if (bus.rd_data_b !== 64'd0) begin bad++; $display("FAIL zero15_b got=%h want=%h", bus.rd_data_b, 64'd0); end
    // Neighbour must be untouched by the discarded write.
    bus.rd_addr_a = 4'd14;
    #1;
    total++;
    if (bus.rd_data_a !== 64'h0123_4567_89AB_CD0E) begin bad++; $display("FAIL zero15_r14 got=%h want=%h", bus.rd_data_a, 64'h0123_4567_89AB_CD0E); end
    // Same write on the ordinary-storage instance lands.
    bus_nz.wr_en = 1'b1; bus_nz.wr_addr = 4'd15; bus_nz.wr_data = ONES;
    @(posedge clk); #1;
    bus_nz.wr_en = 1'b0;
    bus_nz.rd_addr_a = 4'd15; bus_nz.rd_addr_b = 4'd15;
    #1;
    total++;
    if (bus_nz.rd_data_a !== ONES) begin bad++; $display("FAIL nz15_a got=%h want=%h", bus_nz.rd_data_a, ONES); end
    total++;
    if (bus_nz.rd_data_b !== ONES) begin bad++; $display("FAIL nz15_b got=%h want=%h", bus_nz.rd_data_b, ONES); end
  endtask

  task automatic test_same_cycle();
    logic [63:0] exp_pre;
`ifdef REGFILE_WR_BYPASS_EN
    exp_pre = V5;
`else
    exp_pre = 64'h0123_4567_89AB_CD05;
`endif
    @(posedge clk); #1;
    bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd5;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = V5;
    #1;
    total++;
    if (bus.rd_data_a !== exp_pre) begin bad++; $display("FAIL same_pre_a got=%h want=%h", bus.rd_data_a, exp_pre); end
    total++;
    if (bus.rd_data_b !== exp_pre) begin bad++; $display("FAIL same_pre_b got=%h want=%h", bus.rd_data_b, exp_pre); end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    #1;
    total++;
    if (bus.rd_data_a !== V5) begin bad++; $display("FAIL same_post_a got=%h want=%h", bus.rd_data_a, V5); end
    total++;
    if (bus.rd_data_b !== V5) begin bad++; $display("FAIL same_post_b got=%h want=%h", bus.rd_data_b, V5); end
  endtask

  task automatic test_back_to_back();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 64'hA5A5_0000_0000_0002;
    @(posedge clk); #1;
    bus.wr_addr = 4'd9; bus.wr_data = 64'h0000_5A5A_0000_0009;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.rd_addr_a = 4'd2; bus.rd_addr_b = 4'd9;
    #1;
    total++;
    if (bus.rd_data_a !== 64'hA5A5_0000_0000_0002) begin bad++; $display("FAIL b2b_r2 got=%h want=%h", bus.rd_data_a, 64'hA5A5_0000_0000_0002); end
    total++;
    if (bus.rd_data_b !== 64'h0000_5A5A_0000_0009) begin bad++; $display("FAIL b2b_r9 got=%h want=%h", bus.rd_data_b, 64'h0000_5A5A_0000_0009); end
  endtask

  task automatic test_async_reset();
    do_write(4'd7, 64'h1);
    bus.rd_addr_a = 4'd7; bus.rd_addr_b = 4'd7;
    #1;
    total++;
    if (bus.rd_data_a !== 64'h1) begin bad++; $display("FAIL arst_pre_r7 got=%h want=%h", bus.rd_data_a, 64'h1); end
    #2 reset = 1'b1;   // mid-cycle, no clock edge
    #1;
    total++;
    if (bus.rd_data_a !== 64'd0) begin bad++; $display("FAIL arst_now_a got=%h want=%h", bus.rd_data_a, 64'd0); end
    total++;
    if (bus.rd_data_b !== 64'd0) begin bad++; $display("FAIL arst_now_b got=%h want=%h", bus.rd_data_b, 64'd0); end
    #1 reset = 1'b0;
    // Reset held across an edge with a pending write: reset wins.
    @(posedge clk); #1;
    reset = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 64'h1;
    #1;
    total++;
    if (bus.rd_data_a !== 64'd0) begin bad++; $display("FAIL arst_hold_pre got=%h want=%h", bus.rd_data_a, 64'd0); end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    #1;
    total++;
    if (bus.rd_data_a !== 64'd0) begin bad++; $display("FAIL arst_hold_post got=%h want=%h", bus.rd_data_a, 64'd0); end
    reset = 1'b0;
    @(posedge clk); #1;
    bus_nz.rd_addr_a = 4'd15;
    #1;
    total++;
    if (bus.rd_data_b !== 64'd0) begin bad++; $display("FAIL arst_after_r7 got=%h want=%h", bus.rd_data_b, 64'd0); end
    total++;
    if (bus_nz.rd_data_a !== 64'd0) begin bad++; $display("FAIL arst_nz15 got=%h want=%h", bus_nz.rd_data_a, 64'd0); end
  endtask

  initial begin
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus_nz.wr_en = 1'b0; bus_nz.wr_addr = '0; bus_nz.wr_data = '0;
    bus_nz.rd_addr_a = '0; bus_nz.rd_addr_b = '0;
    test_reset();
    test_write_all();
    test_wr_en_low();
    test_zero_reg();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
